// File: rtl/rx_line_editor_pkg.sv
// Shared ASCII codes and input classification for the receive-side line editor.
// Imported by the editor and by the symbol converters that share the same byte set.
package rx_line_editor_pkg;

   localparam logic [7:0] BEL       = 8'h07;
   localparam logic [7:0] BS        = 8'h08;
   localparam logic [7:0] LF        = 8'h0A;
   localparam logic [7:0] CR        = 8'h0D;
   localparam logic [7:0] SP        = 8'h20;
   localparam logic [7:0] DEL       = 8'h7F;
   localparam logic [7:0] PRINT_MIN = 8'h20;
   localparam logic [7:0] PRINT_MAX = 8'h7E;

   typedef enum logic [1:0] {
      CLS_PRINT,
      CLS_ERASE,
      CLS_CR,
      CLS_IGNORE
   } char_class_e;

   function automatic char_class_e classify(input logic [7:0] c);
      if (c >= PRINT_MIN && c <= PRINT_MAX) return CLS_PRINT;
      else if (c == BS || c == DEL)         return CLS_ERASE;
      else if (c == CR)                     return CLS_CR;
      else                                  return CLS_IGNORE;
   endfunction

endpackage

// File: rtl/rx_line_editor.sv
// Buffers keystrokes until CR, handles backspace/delete editing, produces terminal echo,
// then streams the committed line plus a CR terminator to the decoder.
module rx_line_editor
   import rx_line_editor_pkg::*;
#(
   parameter int LINE_LEN = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_valid,
   input  logic [7:0] i_char,
   output logic [7:0] o_echo_char,
   output logic       o_echo_valid,
   input  logic       i_echo_ready,
   output logic [7:0] o_char,
   output logic       o_char_valid,
   input  logic       i_char_ready,
   output logic       o_busy,
   output logic       o_overrun
);

   localparam int            CW   = $clog2(LINE_LEN + 1);
   localparam int            AW   = $clog2(LINE_LEN);
   localparam logic [CW-1:0] FULL = CW'(LINE_LEN);
   localparam logic [CW-1:0] ONE  = CW'(1);

   localparam logic [1:0] S_COLLECT = 2'd0;
   localparam logic [1:0] S_ECHO    = 2'd1;
   localparam logic [1:0] S_RELEASE = 2'd2;

   logic [1:0]    state, state_nxt;
   logic [7:0]    line_buf [LINE_LEN];
   logic [CW-1:0] cnt, rel_idx, rel_nxt;
   logic [7:0]    echo_char, echo_seq1, echo_seq2, line_char;
   logic [1:0]    echo_idx, echo_last;
   logic          echo_crlf, rel_last, overrun;
   logic          accept, echo_fire, echo_done, char_fire;
   char_class_e   in_class;

   assign in_class  = classify(i_char);
   assign accept    = (state == S_COLLECT) && i_valid && (in_class != CLS_IGNORE);
   assign echo_fire = o_echo_valid && i_echo_ready;
   assign echo_done = echo_fire && (echo_idx == echo_last);
   assign char_fire = o_char_valid && i_char_ready;
   assign rel_nxt   = rel_idx + ONE;

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_COLLECT;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_COLLECT: if (accept) state_nxt = S_ECHO;
         S_ECHO:    if (echo_done) state_nxt = echo_crlf ? S_RELEASE : S_COLLECT;
         S_RELEASE: if (char_fire && rel_last) state_nxt = S_COLLECT;
         default:   state_nxt = S_COLLECT;
      endcase
   end

   always_comb begin
      o_echo_valid = (state == S_ECHO);
      o_char_valid = (state == S_RELEASE);
      o_busy       = (state != S_COLLECT);
   end

   // Line storage and the trailing echo bytes carry no reset; they are only read once qualified.
   always_ff @(posedge i_clk) begin
      if (accept && in_class == CLS_PRINT && cnt != FULL) line_buf[cnt[AW-1:0]] <= i_char;
      if (accept && in_class == CLS_ERASE) begin
         echo_seq1 <= SP;
         echo_seq2 <= BS;
      end else if (accept && in_class == CLS_CR) begin
         echo_seq1 <= LF;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt       <= '0;
         echo_char <= '0;
         line_char <= '0;
         echo_idx  <= '0;
         echo_last <= '0;
         echo_crlf <= 1'b0;
         rel_idx   <= '0;
         rel_last  <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         overrun <= i_valid && (state != S_COLLECT);
         if (accept) begin
            echo_idx  <= '0;
            echo_last <= 2'd0;
            echo_crlf <= 1'b0;
            case (in_class)
               CLS_PRINT: begin
                  if (cnt != FULL) begin
                     cnt       <= cnt + ONE;
                     echo_char <= i_char;
                  end else begin
                     echo_char <= BEL;
                  end
               end
               CLS_ERASE: begin
                  if (cnt != '0) begin
                     cnt       <= cnt - ONE;
                     echo_char <= BS;
                     echo_last <= 2'd2;
                  end else begin
                     echo_char <= BEL;
                  end
               end
               CLS_CR: begin
                  echo_char <= CR;
                  echo_last <= 2'd1;
                  echo_crlf <= 1'b1;
               end
               default: ;
            endcase
         end
         if (echo_fire) begin
            echo_idx  <= echo_idx + 2'd1;
            echo_char <= (echo_idx == 2'd0) ? echo_seq1 : echo_seq2;
            // Preload the first release byte so o_char is valid right after the LF goes out.
            if (echo_done && echo_crlf) begin
               rel_idx   <= '0;
               rel_last  <= (cnt == '0);
               line_char <= (cnt == '0) ? CR : line_buf[0];
            end
         end
         if (char_fire) begin
            if (rel_last) begin
               cnt <= '0;
            end else begin
               rel_idx <= rel_nxt;
               if (rel_nxt == cnt) begin
                  line_char <= CR;
                  rel_last  <= 1'b1;
               end else begin
                  line_char <= line_buf[rel_nxt[AW-1:0]];
               end
            end
         end
      end
   end

   assign o_echo_char = echo_char;
   assign o_char      = line_char;
   assign o_overrun   = overrun;

endmodule

// File: tb/tb_rx_line_editor.sv
// Bench for rx_line_editor: two instances (LINE_LEN 16 and 4) behind a select mux,
// checked against a queue-based model of the editing rules.
module tb_rx_line_editor;

   typedef logic [7:0] byte_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   logic  sel = 1'b0;
   logic  valid = 1'b0;
   byte_t ch = 8'h00;
   logic  echo_ready = 1'b1;
   logic  char_ready = 1'b1;
   logic  rand_rdy = 1'b0;

   byte_t e16_char, e4_char, c16_char, c4_char;
   logic  e16_valid, e4_valid, c16_valid, c4_valid, busy16, busy4, ovr16, ovr4;
   byte_t echo_char, line_char;
   logic  echo_valid, char_valid, busy, overrun;

   int checks = 0;
   int failures = 0;

   byte_t got_echo[$], got_line[$], exp_echo[$], exp_line[$];

   always #5 clk = ~clk;

   rx_line_editor dut16 (
      .i_clk(clk), .i_rst(rst), .i_valid(valid & ~sel), .i_char(ch),
      .o_echo_char(e16_char), .o_echo_valid(e16_valid), .i_echo_ready(echo_ready),
      .o_char(c16_char), .o_char_valid(c16_valid), .i_char_ready(char_ready),
      .o_busy(busy16), .o_overrun(ovr16)
   );

   rx_line_editor #(.LINE_LEN(4)) dut4 (
      .i_clk(clk), .i_rst(rst), .i_valid(valid & sel), .i_char(ch),
      .o_echo_char(e4_char), .o_echo_valid(e4_valid), .i_echo_ready(echo_ready),
      .o_char(c4_char), .o_char_valid(c4_valid), .i_char_ready(char_ready),
      .o_busy(busy4), .o_overrun(ovr4)
   );

   assign echo_char  = sel ? e4_char   : e16_char;
   assign echo_valid = sel ? e4_valid  : e16_valid;
   assign line_char  = sel ? c4_char   : c16_char;
   assign char_valid = sel ? c4_valid  : c16_valid;
   assign busy       = sel ? busy4     : busy16;
   assign overrun    = sel ? ovr4      : ovr16;

   // Transfers happen at the next rising edge; record them half a cycle early.
   always @(negedge clk) begin
      if (echo_valid && echo_ready) got_echo.push_back(echo_char);
      if (char_valid && char_ready) got_line.push_back(line_char);
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) begin
            echo_ready = 1'($urandom_range(0, 1));
            char_ready = 1'($urandom_range(0, 1));
         end
      end
   end

   // Reference: what a terminal user should see and what the decoder should receive.
   task automatic model_run(input byte_t seq[$], input int ll);
      byte_t line[$];
      exp_echo.delete();
      exp_line.delete();
      foreach (seq[i]) begin
         byte_t b;
         b = seq[i];
         if (b >= 8'h20 && b <= 8'h7E) begin
            if (line.size() < ll) begin
               line.push_back(b);
               exp_echo.push_back(b);
            end else begin
               exp_echo.push_back(8'h07);
            end
         end else if (b == 8'h08 || b == 8'h7F) begin
            if (line.size() > 0) begin
               void'(line.pop_back());
               exp_echo.push_back(8'h08);
               exp_echo.push_back(8'h20);
               exp_echo.push_back(8'h08);
            end else begin
               exp_echo.push_back(8'h07);
            end
         end else if (b == 8'h0D) begin
            exp_echo.push_back(8'h0D);
            exp_echo.push_back(8'h0A);
            foreach (line[j]) exp_line.push_back(line[j]);
            exp_line.push_back(8'h0D);
            line.delete();
         end
      end
   endtask

   task automatic type_seq(input byte_t seq[$]);
      foreach (seq[i]) begin
         int n;
         n = 0;
         while (busy && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
         end
         valid = 1'b1;
         ch    = seq[i];
         @(posedge clk);
         #1;
         valid = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((got_echo.size() < exp_echo.size() || got_line.size() < exp_line.size() || busy)
             && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         checks++;
         if (echo_valid !== 1'b0 || char_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl sel=%0d got ev=%b cv=%b busy=%b ovr=%b required 0 0 0 0",
                     s, echo_valid, char_valid, busy, overrun);
         end
         checks++;
         if (echo_char !== 8'h00 || line_char !== 8'h00) begin
            failures++;
            $display("FAIL reset_data sel=%0d got echo=%h char=%h required 00 00", s, echo_char, line_char);
         end
      end
      sel = 1'b0;
   endtask

   task automatic test_directed();
      for (int k = 0; k < 4; k++) begin
         byte_t seq[$];
         case (k)
            0: seq = '{8'h31, 8'h32, 8'h2B, 8'h0D};
            1: seq = '{8'h31, 8'h32, 8'h33, 8'h08, 8'h7F, 8'h0D};
            2: seq = '{8'h08, 8'h0D};
            default: seq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h0D};
         endcase
         sel = (k == 3);
         echo_ready = 1'b1;
         char_ready = 1'b1;
         #1;
         model_run(seq, (k == 3) ? 4 : 16);
         got_echo.delete();
         got_line.delete();
         type_seq(seq);
         wait_drain();
         checks++;
         if (got_echo.size() != exp_echo.size() || got_line.size() != exp_line.size()) begin
            failures++;
            $display("FAIL dir%0d_len got echo=%0d line=%0d required echo=%0d line=%0d",
                     k, got_echo.size(), got_line.size(), exp_echo.size(), exp_line.size());
         end
         for (int i = 0; i < exp_echo.size() && i < got_echo.size(); i++) begin
            checks++;
            if (got_echo[i] !== exp_echo[i]) begin
               failures++;
               $display("FAIL dir%0d_echo[%0d] got=%h required=%h", k, i, got_echo[i], exp_echo[i]);
            end
         end
         for (int i = 0; i < exp_line.size() && i < got_line.size(); i++) begin
            checks++;
            if (got_line[i] !== exp_line[i]) begin
               failures++;
               $display("FAIL dir%0d_line[%0d] got=%h required=%h", k, i, got_line[i], exp_line[i]);
            end
         end
         checks++;
         if (busy !== 1'b0) begin
            failures++;
            $display("FAIL dir%0d_idle got busy=%b required 0", k, busy);
         end
      end
      sel = 1'b0;
   endtask

   task automatic test_overrun();
      byte_t seq[$];
      byte_t hold;
      int    n, pulses;
      logic  stable;
      seq = '{8'h61, 8'h62, 8'h0D};
      sel = 1'b0;
      echo_ready = 1'b1;
      char_ready = 1'b0;
      model_run(seq, 16);
      got_echo.delete();
      got_line.delete();
      type_seq(seq);
      n = 0;
      while (!char_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      hold = line_char;
      checks++;
      if (char_valid !== 1'b1 || hold !== exp_line[0]) begin
         failures++;
         $display("FAIL ovr_first got valid=%b char=%h required 1 %h", char_valid, hold, exp_line[0]);
      end
      valid = 1'b1;
      ch    = 8'h35;
      @(posedge clk);
      #1;
      valid = 1'b0;
      checks++;
      if (overrun !== 1'b1) begin
         failures++;
         $display("FAIL ovr_pulse got=%b required=1", overrun);
      end
      pulses = 0;
      stable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (overrun) pulses++;
         if (!char_valid || line_char !== hold) stable = 1'b0;
      end
      checks++;
      if (pulses != 0) begin
         failures++;
         $display("FAIL ovr_single got extra_pulses=%0d required=0", pulses);
      end
      checks++;
      if (!stable) begin
         failures++;
         $display("FAIL ovr_stall_stable got char=%h valid=%b required %h 1", line_char, char_valid, hold);
      end
      char_ready = 1'b1;
      wait_drain();
      checks++;
      if (got_line.size() != exp_line.size()) begin
         failures++;
         $display("FAIL ovr_len got=%0d required=%0d", got_line.size(), exp_line.size());
      end
      for (int i = 0; i < exp_line.size() && i < got_line.size(); i++) begin
         checks++;
         if (got_line[i] !== exp_line[i]) begin
            failures++;
            $display("FAIL ovr_line[%0d] got=%h required=%h", i, got_line[i], exp_line[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      byte_t seq[$];
      int    n;
      seq = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h0D};
      sel = 1'b0;
      echo_ready = 1'b1;
      char_ready = 1'b0;
      model_run(seq, 16);
      got_echo.delete();
      got_line.delete();
      type_seq(seq);
      n = 0;
      while (!char_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      char_ready = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      char_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (echo_valid !== 1'b0 || char_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_ctrl got ev=%b cv=%b busy=%b required 0 0 0", echo_valid, char_valid, busy);
      end
      checks++;
      if (got_line.size() != 2) begin
         failures++;
         $display("FAIL rstmid_sent got=%0d required=2", got_line.size());
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (char_valid !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_quiet got cv=%b required=0", char_valid);
      end
      seq = '{8'h37, 8'h0D};
      char_ready = 1'b1;
      model_run(seq, 16);
      got_echo.delete();
      got_line.delete();
      type_seq(seq);
      wait_drain();
      checks++;
      if (got_line.size() != 2 || got_line[0] !== 8'h37 || got_line[1] !== 8'h0D) begin
         failures++;
         $display("FAIL rstmid_after got n=%0d b0=%h b1=%h required n=2 37 0d",
                  got_line.size(), (got_line.size() > 0) ? got_line[0] : 8'hxx,
                  (got_line.size() > 1) ? got_line[1] : 8'hxx);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         byte_t seq[$];
         int    len;
         sel = it[0];
         #1;
         len = $urandom_range(3, 22);
         for (int j = 0; j < len; j++) begin
            int r;
            r = $urandom_range(0, 11);
            if (r < 7)       seq.push_back(8'($urandom_range(32, 126)));
            else if (r == 7) seq.push_back(8'h08);
            else if (r == 8) seq.push_back(8'h7F);
            else if (r == 9) seq.push_back(8'h0A);
            else if (r == 10) seq.push_back(8'($urandom_range(128, 255)));
            else             seq.push_back(8'h0D);
         end
         seq.push_back(8'h0D);
         model_run(seq, sel ? 4 : 16);
         got_echo.delete();
         got_line.delete();
         rand_rdy = 1'b1;
         type_seq(seq);
         wait_drain();
         rand_rdy = 1'b0;
         @(posedge clk);
         #1;
         echo_ready = 1'b1;
         char_ready = 1'b1;
         checks++;
         if (got_echo.size() != exp_echo.size() || got_line.size() != exp_line.size()) begin
            failures++;
            $display("FAIL rnd%0d_len got echo=%0d line=%0d required echo=%0d line=%0d",
                     it, got_echo.size(), got_line.size(), exp_echo.size(), exp_line.size());
         end
         for (int i = 0; i < exp_echo.size() && i < got_echo.size(); i++) begin
            checks++;
            if (got_echo[i] !== exp_echo[i]) begin
               failures++;
               $display("FAIL rnd%0d_echo[%0d] got=%h required=%h", it, i, got_echo[i], exp_echo[i]);
            end
         end
         for (int i = 0; i < exp_line.size() && i < got_line.size(); i++) begin
            checks++;
            if (got_line[i] !== exp_line[i]) begin
               failures++;
               $display("FAIL rnd%0d_line[%0d] got=%h required=%h", it, i, got_line[i], exp_line[i]);
            end
         end
      end
      sel = 1'b0;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_overrun();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rx_line_editor.md
# rx_line_editor

Interactive line editor between the UART receiver and the calculator's ASCII-to-symbol decoder. Buffers received characters until carriage return and supports backspace/delete editing. Generates terminal echo for a TX-side merge, then releases the committed line in order, followed by a CR terminator. The DAU therefore never sees keystrokes that the user deleted.

## Interface
- `LINE_LEN`, 16: maximum buffered characters per line, excluding the terminator; ≥ 2.
- `i_clk` input 1: system clock.
- `i_rst` input 1: synchronous, active-high reset.
- `i_valid` input 1: single-cycle strobe; `i_char` is valid (driven from UART rx_done).
- `i_char` input 8: received ASCII byte.
- `o_echo_char` output 8: echo byte to the TX path.
- `o_echo_valid` output 1: echo byte available.
- `i_echo_ready` input 1: TX path accepts the echo byte.
- `o_char` output 8: committed line byte to the decoder/DAU.
- `o_char_valid` output 1: line byte available.
- `i_char_ready` input 1: downstream accepts the line byte.
- `o_busy` output 1: high whenever state ≠ COLLECT.
- `o_overrun` output 1: one-cycle pulse when an input byte is dropped.

## Operation
- States:
  - COLLECT: accept input.
  - ECHO: send 1–3 echo bytes.
  - RELEASE: stream the buffer, then CR.
- Buffer: `LINE_LEN` × 8 register array with write count `cnt` (0..`LINE_LEN`). `cnt` width is `$clog2(LINE_LEN+1)`.
- Input classification in COLLECT, on `i_valid`:
  - Printable (0x20–0x7E), `cnt < LINE_LEN`: store at `buf[cnt]`, `cnt++`, echo the byte.
  - Printable, `cnt == LINE_LEN`: discard the byte, echo BEL (0x07).
  - BS (0x08) or DEL (0x7F), `cnt > 0`: `cnt--`, echo BS, SP, BS (0x08 0x20 0x08).
  - BS or DEL, `cnt == 0`: echo BEL.
  - CR (0x0D): echo CR, LF (0x0D 0x0A). After the echo completes, go to RELEASE.
  - LF and all other bytes: ignored; no echo, no state change, no overrun pulse.
- ECHO:
  - Holds a sequence register of up to 3 bytes plus an index.
  - Each echo byte completes on `o_echo_valid & i_echo_ready`.
  - After the last byte: go to RELEASE if the sequence was CR/LF, otherwise return to COLLECT.
- RELEASE:
  - Emits `buf[0..cnt-1]` through the `o_char` handshake, then 0x0D.
  - On the CR transfer: `cnt ← 0`, return to COLLECT.
  - An empty line emits only 0x0D.
- Drop rule: `i_valid` in ECHO or RELEASE discards the byte and pulses `o_overrun` in the following cycle. Buffer, echo and release continue unaffected.

## Timing
- Reset values:
  - State COLLECT, `cnt = 0`.
  - All valid outputs, `o_busy` and `o_overrun` are 0.
  - `o_echo_char` and `o_char` are 0x00.
  - Buffer contents are don't-care.
- Handshakes:
  - Valid/ready: transfer occurs on a cycle with valid & ready.
  - Once asserted, valid and data stay stable until transfer.
  - Valid never depends combinationally on ready.
- Echo latency: an input byte on `i_valid` at cycle N gives the first echo byte valid at N+1. With ready held high, one echo byte per cycle; a 3-byte sequence completes at N+3.
- Release latency: the first line byte is valid in the cycle after the final echo (LF) transfer. With `i_char_ready` held high, one byte per cycle; a line of k bytes ends with CR transferred at release start + k.
- Backpressure on either port stalls that state indefinitely; there is no timeout.
- Reset mid-operation: returns to COLLECT with `cnt = 0` in the next cycle. The partial echo or release is abandoned; no further valid is asserted.

## Structure
- ASCII constants go in shared header `ascii_codes.vh`, included by this block and the symbol converters: BEL, BS, LF, CR, SP, DEL, PRINT_MIN, PRINT_MAX.
- State encoding uses localparams inside the block.
- Single module; no sub-module. Buffer storage, echo sequencer and release counter are inline.
- Integration: the TX side needs a 2-input merge (echo vs DAU output) ahead of the TX FIFO. That merge is a separate block.

## Test plan
- Type "12+" then CR, both readies high:
  - Echo stream: 0x31 0x32 0x2B 0x0D 0x0A.
  - Line stream: 0x31 0x32 0x2B 0x0D.
  - `o_busy` low afterwards.
- Type "123", then BS, then DEL, then CR:
  - Echo: 1 2 3, BS SP BS, BS SP BS, CR LF.
  - Line stream: 0x31 0x0D.
- BS on an empty line, then CR:
  - Echo: 0x07, then 0x0D 0x0A.
  - Line stream: 0x0D only.
- With `LINE_LEN=4`, type "12345" then CR:
  - Fifth byte echoes 0x07.
  - Line stream: 0x31 0x32 0x33 0x34 0x0D.
- Hold `i_char_ready` low during RELEASE and inject an `i_valid` byte:
  - `o_overrun` pulses once.
  - Released data unchanged after ready returns.
  - `o_char` held stable throughout the stall.
- Assert `i_rst` while in RELEASE, after 2 of 5 bytes have transferred:
  - Next cycle: valids low, `cnt = 0`.
  - A following "7" then CR gives line stream 0x37 0x0D.
